// File: rtl/ld_counter.sv
// Loadable SIZE-bit up/down counter advanced by rising edges of a slow tick level,
// sampled in the fsys domain; tc pulses for one cycle after every counting wrap.
module ld_counter #(
    parameter int SIZE = 4
) (
    input  logic            ld_counter_fsys,
    input  logic            ld_counter_rst,
    input  logic            ld_counter_tick,
    input  logic            ld_counter_en,
    input  logic            ld_counter_up,
    input  logic            ld_counter_load,
    input  logic [SIZE-1:0] ld_counter_din,
    output logic [SIZE-1:0] ld_counter_q,
    output logic            ld_counter_tc
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    logic            t1_reg;
    logic            t2_reg;
    logic            step;
    logic [SIZE-1:0] q_reg;
    logic [SIZE-1:0] q_next;
    logic            tc_reg;
    logic            tc_next;

    assign step = t1_reg & ~t2_reg;

    // Load outranks a same-cycle step, which is dropped rather than deferred.
    always_comb begin
        q_next  = q_reg;
        tc_next = 1'b0;
        if (ld_counter_load) begin
            q_next = ld_counter_din;
        end else if (step && ld_counter_en) begin
            if (ld_counter_up) begin
                q_next  = q_reg + ONE;
                tc_next = &q_reg;
            end else begin
                q_next  = q_reg - ONE;
                tc_next = ~|q_reg;
            end
        end
    end

    // Sync chain presets high so a tick already high at reset release is not counted.
    always_ff @(posedge ld_counter_fsys) begin
        if (ld_counter_rst) begin
            t1_reg <= 1'b1;
            t2_reg <= 1'b1;
            q_reg  <= '0;
            tc_reg <= 1'b0;
        end else begin
            t1_reg <= ld_counter_tick;
            t2_reg <= t1_reg;
            q_reg  <= q_next;
            tc_reg <= tc_next;
        end
    end

    assign ld_counter_q  = q_reg;
    assign ld_counter_tc = tc_reg;

endmodule

// File: tb/tb_ld_counter.sv
// Directed plus randomized bench for ld_counter, checked every cycle against a
// tick-history/arithmetic reference model.
module tb_ld_counter;

    localparam int SIZE = 4;
    localparam int M    = 1 << SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tick = 1'b1;
    logic            en = 1'b0;
    logic            up = 1'b1;
    logic            load = 1'b0;
    logic [SIZE-1:0] din = '0;
    logic [SIZE-1:0] q;
    logic            tc;

    int checks = 0;
    int errors = 0;
    int tc_seen = 0;
    int tc_q = -1;

    // Reference model: counter value, pending tc and the tick samples taken so far.
    int m_q  = 0;
    int m_tc = 0;
    bit hist[$];

    ld_counter #(.SIZE(SIZE)) dut (
        .ld_counter_fsys (clk),
        .ld_counter_rst  (rst),
        .ld_counter_tick (tick),
        .ld_counter_en   (en),
        .ld_counter_up   (up),
        .ld_counter_load (load),
        .ld_counter_din  (din),
        .ld_counter_q    (q),
        .ld_counter_tc   (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // A step happens when the last two samples of tick read 0 then 1.
    task automatic model_edge();
        bit stp;
        stp = (hist.size() >= 2) && hist[hist.size()-1] && !hist[hist.size()-2];
        if (rst) begin
            m_q  = 0;
            m_tc = 0;
            hist = '{1'b1, 1'b1};
        end else begin
            hist.push_back(tick);
            if (hist.size() > 2) void'(hist.pop_front());
            m_tc = 0;
            if (load) begin
                m_q = int'(din);
            end else if (stp && en) begin
                if (up) begin
                    m_tc = (m_q == M - 1);
                    m_q  = (m_q + 1) % M;
                end else begin
                    m_tc = (m_q == 0);
                    m_q  = (m_q + M - 1) % M;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("q", 32'(q), 32'(m_q));
        check("tc", 32'(tc), 32'(m_tc));
        if (tc === 1'b1) begin
            tc_seen++;
            tc_q = int'(q);
        end
    endtask

    task automatic run_ticks(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            tick = 1'b0;
            for (int k = 0; k < half; k++) cycle();
            tick = 1'b1;
            for (int k = 0; k < half; k++) cycle();
        end
        tick = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic load_val(input int v);
        load = 1'b1;
        din  = SIZE'(v);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        // Reset with tick held high, then release: no spurious step.
        rst = 1'b1; tick = 1'b1; en = 1'b1; up = 1'b1;
        cycle();
        cycle();
        check("rst_q", 32'(q), 0);
        check("rst_tc", 32'(tc), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("no_spurious_step", 32'(q), 0);

        // Count up 17 ticks at the fastest legal tick rate.
        tc_seen = 0;
        run_ticks(17, 1);
        check("up17_q", 32'(q), 1);
        check("up17_tc_count", 32'(tc_seen), 1);
        check("up17_tc_at_zero", 32'(tc_q), 0);

        // Count down through zero; the load itself gives no tc.
        tc_seen = 0;
        load_val(0);
        check("load0_tc", 32'(tc), 0);
        up = 1'b0;
        run_ticks(2, 2);
        check("down_q", 32'(q), 14);
        check("down_tc_count", 32'(tc_seen), 1);

        // Load collides with a step: step is lost, next tick gives B.
        up = 1'b1;
        tick = 1'b0;
        cycle();
        cycle();
        tick = 1'b1;
        cycle();
        load_val(10);
        check("load_vs_step", 32'(q), 10);
        run_ticks(1, 2);
        check("after_load_step", 32'(q), 11);

        // Enable gating: missed ticks are not replayed.
        load_val(5);
        en = 1'b0;
        run_ticks(3, 2);
        check("en_low_hold", 32'(q), 5);
        en = 1'b1;
        run_ticks(1, 2);
        check("en_high_step", 32'(q), 6);

        // Reset while a step is pending in the sync chain.
        load_val(7);
        tick = 1'b0;
        cycle();
        cycle();
        tick = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        check("midrst_q", 32'(q), 0);
        check("midrst_tc", 32'(tc), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("midrst_no_step", 32'(q), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            load = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            din  = SIZE'($urandom());
            if ($urandom_range(0, 2) == 0) tick = ~tick;
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
